// File: rtl/seq_pattern_det.sv
// Programmable DEPTH-symbol sequence detector with per-bit mask and overlap mode.
// Latency: one cycle from the completing symbol's edge to z / match_cnt update.
// Backpressure: none; every in_valid symbol is accepted unless cfg_load is set.
module seq_pattern_det #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 3,
    parameter int CNT_W = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       din,
    input  logic                   cfg_load,
    input  logic [DEPTH*WIDTH-1:0] cfg_pattern,
    input  logic [DEPTH*WIDTH-1:0] cfg_mask,
    input  logic                   cfg_overlap,
    output logic                   z,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   armed
);

    localparam int PW     = DEPTH * WIDTH;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    // Architectural state
    logic [PW-1:0]     hist_q;
    logic [PW-1:0]     pat_q;
    logic [PW-1:0]     msk_q;
    logic              ovl_q;
    logic [FILL_W-1:0] fill_q;
    logic              z_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              armed_q;

    // Next-state values
    logic [PW-1:0]     hist_d;
    logic [PW-1:0]     pat_d;
    logic [PW-1:0]     msk_d;
    logic              ovl_d;
    logic [FILL_W-1:0] fill_d;
    logic              z_d;
    logic [CNT_W-1:0]  cnt_d;

    // Candidate history/fill if the current din is accepted
    logic [PW-1:0]     hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic [DEPTH-1:0]  sym_ok;
    logic              window_hit;
    logic              cnt_sat;

    // Newest symbol enters the top slot; the oldest (slot 0) falls off the bottom.
    generate
        if (DEPTH == 1) begin : g_shift_single
            assign hist_shift = din;
        end else begin : g_shift_multi
            assign hist_shift = {din, hist_q[PW-1:WIDTH]};
        end
    endgenerate

    // Fill saturates at DEPTH; once full, the window simply slides.
    assign fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

    // Per-slot masked compare against the shifted-in window.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
            assign sym_ok[k] = ((hist_shift[k*WIDTH +: WIDTH] ^ pat_q[k*WIDTH +: WIDTH])
                                & msk_q[k*WIDTH +: WIDTH]) == '0;
        end
    endgenerate

    // A window only counts once DEPTH fresh symbols have been seen since restart.
    assign window_hit = (fill_inc == FILL_FULL) && (&sym_ok);
    assign cnt_sat    = (cnt_q == {CNT_W{1'b1}});

    // Next-state selection: cfg_load wins over an accepted symbol; z is a pulse.
    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        msk_d  = msk_q;
        ovl_d  = ovl_q;
        fill_d = fill_q;
        z_d    = 1'b0;
        cnt_d  = cnt_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            msk_d  = cfg_mask;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (window_hit) begin
                z_d = 1'b1;
                if (!cnt_sat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Non-overlapping: the matched symbols cannot seed the next match.
                if (!ovl_q) begin
                    fill_d = '0;
                end
            end
        end
    end

    // State register with synchronous reset to the power-on configuration.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hist_q  <= '0;
            pat_q   <= '0;
            msk_q   <= '1;
            ovl_q   <= 1'b1;
            fill_q  <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            msk_q   <= msk_d;
            ovl_q   <= ovl_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            armed_q <= (fill_d == FILL_FULL);
        end
    end

    // Outputs come straight from flops; no input-to-output combinational path.
    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign armed     = armed_q;

endmodule

// File: tb/tb_seq_pattern_det.sv
// Directed bench for seq_pattern_det (WIDTH=2, DEPTH=3) plus a CNT_W=2 copy.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Both instances share stimulus; the narrow-counter copy is checked for saturation.
module tb_seq_pattern_det;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] din = 2'b00;
    logic       cfg_load = 1'b0;
    logic [5:0] cfg_pattern = 6'd0;
    logic [5:0] cfg_mask = 6'h3f;
    logic       cfg_overlap = 1'b1;

    logic       z;
    logic [7:0] match_cnt;
    logic       armed;
    logic       z2;
    logic [1:0] match_cnt2;
    logic       armed2;

    int checks = 0;
    int errors = 0;

    seq_pattern_det #(.WIDTH(2), .DEPTH(3), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .z(z), .match_cnt(match_cnt), .armed(armed)
    );

    seq_pattern_det #(.WIDTH(2), .DEPTH(3), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .z(z2), .match_cnt(match_cnt2), .armed(armed2)
    );

    always #5 Clk = ~Clk;

    function automatic logic [5:0] pk(input logic [1:0] s0, input logic [1:0] s1,
                                      input logic [1:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] s);
        in_valid = 1'b1;
        din      = s;
        tick();
        in_valid = 1'b0;
        din      = 2'b00;
    endtask

    task automatic load_cfg(input logic [5:0] p, input logic [5:0] m, input logic o);
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] ez;
        do_reset();
        checks++;
        if (z !== 1'b0) begin errors++; $display("FAIL reset_z: got %b want 0", z); end
        checks++;
        if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b want 0", armed); end
        // Reset configuration is pattern 0, full mask, overlap: three 00 symbols hit.
        ez = 3'b100;
        for (int i = 0; i < 3; i++) begin
            send(2'b00);
            checks++;
            if (z !== ez[i]) begin errors++; $display("FAIL reset_default_z[%0d]: got %b want %b", i, z, ez[i]); end
        end
        checks++;
        if (match_cnt !== 8'd1) begin errors++; $display("FAIL reset_default_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_basic();
        logic [1:0] syms [4];
        logic [3:0] ez;
        logic [3:0] ea;
        do_reset();
        load_cfg(pk(2'b01, 2'b11, 2'b11), 6'h3f, 1'b1);
        syms = '{2'b01, 2'b11, 2'b11, 2'b00};
        ez = 4'b0100;
        ea = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            send(syms[i]);
            checks++;
            if (z !== ez[i]) begin errors++; $display("FAIL basic_z[%0d]: got %b want %b", i, z, ez[i]); end
            checks++;
            if (armed !== ea[i]) begin errors++; $display("FAIL basic_armed[%0d]: got %b want %b", i, armed, ea[i]); end
        end
        checks++;
        if (match_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_overlap();
        logic [5:0] ez;
        do_reset();
        load_cfg(pk(2'b11, 2'b11, 2'b11), 6'h3f, 1'b1);
        ez = 6'b111100;
        for (int i = 0; i < 6; i++) begin
            send(2'b11);
            checks++;
            if (z !== ez[i]) begin errors++; $display("FAIL ovl1_z[%0d]: got %b want %b", i, z, ez[i]); end
        end
        checks++;
        if (match_cnt !== 8'd4) begin errors++; $display("FAIL ovl1_cnt: got %0d want 4", match_cnt); end

        do_reset();
        load_cfg(pk(2'b11, 2'b11, 2'b11), 6'h3f, 1'b0);
        ez = 6'b100100;
        for (int i = 0; i < 6; i++) begin
            send(2'b11);
            checks++;
            if (z !== ez[i]) begin errors++; $display("FAIL ovl0_z[%0d]: got %b want %b", i, z, ez[i]); end
            if (i == 2) begin
                checks++;
                if (armed !== 1'b0) begin errors++; $display("FAIL ovl0_armed_after_hit: got %b want 0", armed); end
            end
        end
        checks++;
        if (match_cnt !== 8'd2) begin errors++; $display("FAIL ovl0_cnt: got %0d want 2", match_cnt); end
    endtask

    task automatic test_gaps_and_reset();
        do_reset();
        load_cfg(pk(2'b01, 2'b11, 2'b11), 6'h3f, 1'b1);
        send(2'b01);
        send(2'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (z !== 1'b0) begin errors++; $display("FAIL gap_idle_z[%0d]: got %b want 0", i, z); end
        end
        send(2'b11);
        checks++;
        if (z !== 1'b1) begin errors++; $display("FAIL gap_hit_z: got %b want 1", z); end
        checks++;
        if (match_cnt !== 8'd1) begin errors++; $display("FAIL gap_hit_cnt: got %0d want 1", match_cnt); end

        send(2'b01);
        send(2'b11);
        do_reset();
        checks++;
        if (match_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", match_cnt); end
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL midrst_armed: got %b want 0", armed); end
        send(2'b11);
        checks++;
        if (z !== 1'b0) begin errors++; $display("FAIL midrst_z: got %b want 0", z); end
    endtask

    task automatic test_mask();
        logic [1:0] syms [6];
        logic [5:0] ez;
        do_reset();
        load_cfg(pk(2'b00, 2'b11, 2'b10), pk(2'b00, 2'b11, 2'b11), 1'b1);
        syms = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11};
        ez = 6'b000100;
        for (int i = 0; i < 6; i++) begin
            send(syms[i]);
            checks++;
            if (z !== ez[i]) begin errors++; $display("FAIL mask_z[%0d]: got %b want %b", i, z, ez[i]); end
        end
        checks++;
        if (match_cnt !== 8'd1) begin errors++; $display("FAIL mask_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_load_collision();
        logic [1:0] syms [3];
        logic [2:0] ez;
        do_reset();
        load_cfg(pk(2'b01, 2'b11, 2'b11), 6'h3f, 1'b1);
        send(2'b01);
        send(2'b11);
        // Load and a valid symbol on the same edge: the symbol must be dropped.
        in_valid = 1'b1;
        din      = 2'b11;
        load_cfg(pk(2'b01, 2'b11, 2'b11), 6'h3f, 1'b1);
        in_valid = 1'b0;
        din      = 2'b00;
        checks++;
        if (z !== 1'b0) begin errors++; $display("FAIL collide_z: got %b want 0", z); end
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL collide_armed: got %b want 0", armed); end
        syms = '{2'b01, 2'b11, 2'b11};
        ez = 3'b100;
        for (int i = 0; i < 3; i++) begin
            send(syms[i]);
            checks++;
            if (z !== ez[i]) begin errors++; $display("FAIL collide_refill_z[%0d]: got %b want %b", i, z, ez[i]); end
        end
    endtask

    task automatic test_saturation();
        logic [6:0] ez;
        int exp_c;
        do_reset();
        load_cfg(pk(2'b11, 2'b11, 2'b11), 6'h3f, 1'b1);
        ez = 7'b1111100;
        exp_c = 0;
        for (int i = 0; i < 7; i++) begin
            send(2'b11);
            if (ez[i] && exp_c < 3) exp_c++;
            checks++;
            if (z2 !== ez[i]) begin errors++; $display("FAIL sat_z[%0d]: got %b want %b", i, z2, ez[i]); end
            checks++;
            if (match_cnt2 !== 2'(exp_c)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, match_cnt2, exp_c); end
        end
        checks++;
        if (match_cnt !== 8'd5) begin errors++; $display("FAIL wide_cnt: got %0d want 5", match_cnt); end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_overlap();
        test_gaps_and_reset();
        test_mask();
        test_load_collision();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
